button_event: RTL and testbench

//  Consumes the debounced, clock-synchronous level from data_sync.stable_out
//  and turns it into single-cycle user-input events: press, release, short press,

---
 rtl/button_event.sv | 90 +++++++++
 tb/tb_button_event.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/button_event.sv
// button_event: turns a debounced button level into press, release, short,
// long and auto-repeat single-cycle events plus a held level.
module button_event #(
    parameter int LONG_CYCLES   = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000,
    parameter bit REPEAT_EN     = 1'b1,
    parameter int CNT_W         = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);
    typedef enum logic [1:0] {ARM, IDLE, PRESSED, HELD} state_t;
    localparam logic [CNT_W-1:0] LONG_T = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_T  = CNT_W'(REPEAT_CYCLES - 1);
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    // ARM waits for an unpressed sample so a button held through reset never fires
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ARM;
            cnt_q         <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
            case (state_q)
                ARM: begin
                    cnt_q <= '0;
                    if (!in) state_q <= IDLE;
                end
                IDLE: begin
                    cnt_q <= '0;
                    if (in) begin
                        press_pulse <= 1'b1;
                        held        <= 1'b1;
                        state_q     <= PRESSED;
                    end
                end
                PRESSED: begin
                    held <= 1'b1;
                    if (!in) begin
                        release_pulse <= 1'b1;
                        short_press   <= 1'b1;
                        state_q       <= IDLE;
                        cnt_q         <= '0;
                    end else if (cnt_q == LONG_T) begin
                        long_press <= 1'b1;
                        state_q    <= HELD;
                        cnt_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HELD: begin
                    held <= 1'b1;
                    if (!in) begin
                        release_pulse <= 1'b1;
                        state_q       <= IDLE;
                        cnt_q         <= '0;
                    end else if (cnt_q == REP_T) begin
                        repeat_pulse <= REPEAT_EN;
                        cnt_q        <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ARM;
                    cnt_q   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_button_event.sv
// tb_button_event: randomized and directed checks of button_event against a
// press-duration model, for REPEAT_EN=1 (index 0) and REPEAT_EN=0 (index 1).
module tb_button_event;
    localparam int L = 8;
    localparam int R = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in  = 1'b0;
    logic [1:0] pp, rp, sp, lp, ep, hd;
    int errors = 0;
    int checks = 0;
    bit armed [2];
    bit pr [2];
    int n [2];
    bit e_pp [2], e_rp [2], e_sp [2], e_lp [2], e_ep [2], e_hd [2];
    bit en [2] = '{1'b1, 1'b0};

    always #5 clk = ~clk;

    button_event #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_EN(1'b1), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .in(in), .press_pulse(pp[0]), .release_pulse(rp[0]),
        .short_press(sp[0]), .long_press(lp[0]), .repeat_pulse(ep[0]), .held(hd[0]));
    button_event #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_EN(1'b0), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .in(in), .press_pulse(pp[1]), .release_pulse(rp[1]),
        .short_press(sp[1]), .long_press(lp[1]), .repeat_pulse(ep[1]), .held(hd[1]));

    task automatic chk(input string nm, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", nm, a, e, $time);
        end
    endtask

    task automatic clear_exp(input int k);
        e_pp[k] = 0; e_rp[k] = 0; e_sp[k] = 0; e_lp[k] = 0; e_ep[k] = 0; e_hd[k] = 0;
    endtask

    // n counts posedges since the press was sampled
    task automatic model(input int k, input logic v);
        clear_exp(k);
        if (!armed[k]) begin
            if (!v) armed[k] = 1;
        end else if (!pr[k]) begin
            if (v) begin
                e_pp[k] = 1; pr[k] = 1; n[k] = 0;
            end
        end else begin
            n[k]++;
            if (!v) begin
                e_rp[k] = 1; e_sp[k] = (n[k] <= L); pr[k] = 0;
            end else begin
                e_lp[k] = (n[k] == L);
                e_ep[k] = en[k] && n[k] > L && ((n[k] - L) % R == 0);
            end
        end
        e_hd[k] = pr[k] || e_rp[k];
    endtask

    always @(posedge rst)
        for (int k = 0; k < 2; k++) begin
            armed[k] = 0; pr[k] = 0; n[k] = 0; clear_exp(k);
        end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++)
            if (rst) clear_exp(k);
            else model(k, in);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("press%0d", k), pp[k], e_pp[k]);
            chk($sformatf("release%0d", k), rp[k], e_rp[k]);
            chk($sformatf("short%0d", k), sp[k], e_sp[k]);
            chk($sformatf("long%0d", k), lp[k], e_lp[k]);
            chk($sformatf("repeat%0d", k), ep[k], e_ep[k]);
            chk($sformatf("held%0d", k), hd[k], e_hd[k]);
        end
    end

    task automatic step(input logic v);
        @(negedge clk);
        in = v;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int c_l1, c_r1, c_r0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_held", hd[0], 0);
        chk("rst_press", pp[0], 0);
        @(negedge clk);
        rst = 0;
        step(0); step(0);
        // short press: press at n=0, release sampled at n=5
        step(1);
        chk("d1_press", pp[0], 1);
        chk("d1_held", hd[0], 1);
        repeat (4) step(1);
        step(0);
        chk("d1_release", rp[0], 1);
        chk("d1_short", sp[0], 1);
        chk("d1_held_rel", hd[0], 1);
        step(0);
        chk("d1_held_off", hd[0], 0);
        // long press with repeats
        step(1);
        for (int i = 1; i < L; i++) step(1);
        chk("d2_nolong", lp[0], 0);
        step(1);
        chk("d2_long", lp[0], 1);
        chk("d2_long_norep", lp[1], 1);
        repeat (R - 1) step(1);
        chk("d2_norep_early", ep[0], 0);
        step(1);
        chk("d2_rep", ep[0], 1);
        chk("d2_rep_dis", ep[1], 0);
        step(0);
        chk("d2_release", rp[0], 1);
        chk("d2_noshort", sp[0], 0);
        // release at the long terminal count
        step(1);
        repeat (L - 1) step(1);
        step(0);
        chk("d3_short", sp[0], 1);
        chk("d3_nolong", lp[0], 0);
        step(1);
        repeat (L + R - 1) step(1);
        step(0);
        chk("d3b_release", rp[0], 1);
        chk("d3b_norep", ep[0], 0);
        chk("d3b_noshort", sp[0], 0);
        // button down across reset release
        @(negedge clk);
        in = 1; rst = 1;
        @(negedge clk);
        rst = 0;
        repeat (20) step(1);
        chk("d4_nopress", pp[0], 0);
        chk("d4_noheld", hd[0], 0);
        step(0);
        step(1);
        chk("d4_press", pp[0], 1);
        // async reset while HELD
        repeat (L + 2) step(1);
        chk("d5_held_before", hd[0], 1);
        @(negedge clk);
        #2 rst = 1;
        #1;
        chk("d5_async_held0", hd[0], 0);
        chk("d5_async_held1", hd[1], 0);
        @(negedge clk);
        rst = 0;
        repeat (3) step(1);
        chk("d5_nopress", pp[0], 0);
        step(0);
        chk("d5_norelease", rp[0], 0);
        step(1);
        chk("d5_press", pp[0], 1);
        step(0);
        chk("d5_release", rp[0], 1);
        // 40 cycles held: one long, repeats only where enabled
        step(1);
        c_l1 = 0; c_r1 = 0; c_r0 = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            c_l1 += int'(lp[1]); c_r1 += int'(ep[1]); c_r0 += int'(ep[0]);
        end
        chk("d6_long_count", c_l1, 1);
        chk("d6_rep_dis_count", c_r1, 0);
        chk("d6_rep_en_count", c_r0, (40 - L) / R);
        step(0);
        // random runs with occasional asynchronous resets
        for (int i = 0; i < 400; i++) begin
            int len;
            logic v;
            len = $urandom_range(1, 20);
            v = $urandom_range(0, 1);
            repeat (len) step(v);
            if ($urandom_range(0, 25) == 0) begin
                @(negedge clk);
                #2 rst = 1;
                #2 rst = 0;
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
